// File: rtl/rom_image_loader.sv
// rom_image_loader: turns a length-prefixed little-endian byte stream into
// word writes to the boot program RAM, validating the image magic word.
module rom_image_loader #(
    parameter logic [31:0] MAGIC     = 32'h4D525341,
    parameter int unsigned MAX_WORDS = 1024,
    parameter logic [29:0] ADDR_BASE = 30'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        mem_write,
    output logic        busy,
    output logic        done,
    output logic        error
);
    typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, DONE, ERROR} state_t;
    state_t      state_q;
    logic [1:0]  bcnt_q;
    logic [29:0] wcnt_q;
    logic [31:0] asm_q, len_q, mem_data_q;
    logic [29:0] mem_addr_q;
    logic        mem_write_q, busy_q, done_q, error_q;
    logic        xfer, last_byte;
    logic [31:0] word_d;
    logic [29:0] wcnt_d;
    assign in_ready  = state_q == LEN || state_q == DATA;
    assign xfer      = in_valid && in_ready;
    assign last_byte = xfer && bcnt_q == 2'd3;
    // Bytes arrive LSB first, so shift each new byte in at the top.
    assign word_d    = {in_data, asm_q[31:8]};
    assign wcnt_d    = wcnt_q + 30'd1;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign mem_write = mem_write_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bcnt_q      <= '0;
            wcnt_q      <= '0;
            asm_q       <= '0;
            len_q       <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_write_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            mem_write_q <= 1'b0;
            if (xfer) begin
                asm_q  <= word_d;
                bcnt_q <= bcnt_q + 2'd1;
            end
            case (state_q)
                IDLE, DONE, ERROR: if (start) begin
                    state_q <= LEN;
                    busy_q  <= 1'b1;
                    done_q  <= 1'b0;
                    error_q <= 1'b0;
                    bcnt_q  <= '0;
                    wcnt_q  <= '0;
                end
                LEN: if (last_byte) begin
                    len_q <= word_d;
                    if (word_d == 32'd0 || word_d > 32'(MAX_WORDS)) begin
                        state_q <= ERROR;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end else begin
                        state_q <= DATA;
                    end
                end
                DATA: if (last_byte) begin
                    if (wcnt_q == '0 && word_d != MAGIC) begin
                        state_q <= ERROR;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end else begin
                        state_q     <= WRITE;
                        mem_write_q <= 1'b1;
                        mem_addr_q  <= ADDR_BASE + wcnt_q;
                        mem_data_q  <= word_d;
                    end
                end
                WRITE: begin
                    wcnt_q <= wcnt_d;
                    if ({2'b00, wcnt_d} == len_q) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= DATA;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/rom_image_loader.md
Name: rom_image_loader

Overview:
- Writer-side counterpart of the synchronous program ROM.
- Accepts a byte stream (from a UART or debug link) carrying a length-prefixed program image.
- Assembles little-endian 32-bit words and checks the image magic word.
- Drives a word-addressed write port (30-bit word address, 32-bit data) of the program RAM that replaces the ROM at boot.

Parameters:
- MAGIC, 32'h4D525341, required value of image word 0 ("ASRM", little-endian).
- MAX_WORDS, 1024, largest accepted image length in words; range 1..2^30-1.
- ADDR_BASE, 30'h0, word address where image word 0 is written.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_addr  output  30  word write address.
- mem_data  output  32  word write data.
- mem_write  output  1  one-cycle write strobe.
- busy  output  1  load in progress.
- done  output  1  level; last load completed successfully.
- error  output  1  level; last load aborted.

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE; all outputs 0; byte counter, word counter and assembly register cleared.
- A byte transfers on a rising edge where in_valid && in_ready. in_ready is combinational from state only; it never depends on in_valid.
- States:
  - IDLE: in_ready=0. start -> LEN; clears done/error, byte count, word count.
  - LEN: in_ready=1. Collects 4 bytes into N, first byte = bits 7:0. After the 4th byte: N==0 or N>MAX_WORDS -> ERROR; else -> DATA.
  - DATA: in_ready=1. Collects 4 bytes, little-endian. After the 4th byte:
    - If word count==0 and word!=MAGIC -> ERROR; no write is issued.
    - Otherwise -> WRITE.
  - WRITE: in_ready=0, lasts exactly 1 cycle. mem_write=1; mem_addr=ADDR_BASE+word count (modulo 2^30); mem_data=assembled word. Word count increments. If new count==N -> DONE, else -> DATA.
  - DONE: done=1, busy=0. start -> LEN.
  - ERROR: error=1, busy=0. start -> LEN.
- busy=1 in LEN, DATA and WRITE.
- start while busy is ignored.
- Bytes presented while in_ready=0 are not consumed; the upstream source holds them.
- Throughput: 5 cycles per word at full in_valid (4 byte cycles + 1 write cycle).
- mem_addr and mem_data are registered and stable while mem_write=1. Outside WRITE they hold their last value; mem_write=0.
- Partial word at stream stall: the loader waits indefinitely. There is no timeout in this block.
- reset low mid-load: immediate return to IDLE. Words already written stay in RAM; done=error=0.

Test Plan:
- Load N=3, words 4D525341, 11223344, DEADBEEF, all bytes back-to-back -> 3 writes at addrs 0,1,2 with those data; done=1 exactly 15 cycles after the last length byte; error=0.
- Word 0 = 4D525342 -> no mem_write at any point; error=1, done=0; start then a valid image -> done=1.
- N=0, and separately N=MAX_WORDS+1 -> error=1 directly after the 4th length byte; in_ready drops.
- Random in_valid gaps, ADDR_BASE=30'h3FFFFFFF, N=2 -> writes to addrs 3FFFFFFF and 0 (wrap), data byte order correct.
- reset pulsed low after 2 data bytes -> all outputs 0 asynchronously; next load starts cleanly from the length field.
- start pulses while busy -> no effect on the word count or addresses; load completes normally.
